// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with a registered one-hot grant. Priority
//               rotates to the port after the last-granted one. The grant is
//               held until it is released, either when the granted request
//               drops (RELEASE=0) or on an acknowledge pulse from the granted
//               port (RELEASE=1). On a release cycle the next winner is picked
//               in the same cycle, so there is no idle cycle between grants.
// Ports       : clk           - single clock, rising edge
//               rst           - synchronous active-high reset
//               request       - per-port request level
//               acknowledge   - per-port release pulse (RELEASE=1 only)
//               grant         - registered one-hot grant
//               grant_valid   - registered, high iff grant is non-zero
//               grant_encoded - registered binary index of the grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int PORTS   = 4,
    parameter int RELEASE = 0,
    localparam int c_idx_w = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORTS-1:0]   request,
    input  logic [PORTS-1:0]   acknowledge,
    output logic [PORTS-1:0]   grant,
    output logic               grant_valid,
    output logic [c_idx_w-1:0] grant_encoded
);

    localparam logic [0:0]         c_st_idle    = 1'b0;
    localparam logic [0:0]         c_st_granted = 1'b1;
    // Last-granted index after reset: makes port 0 the first in line.
    localparam logic [c_idx_w-1:0] c_last_rst   = c_idx_w'(PORTS - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_idx_w-1:0] r_last;
    logic [c_idx_w-1:0] w_last_nxt;
    logic [PORTS-1:0]   r_grant;
    logic [PORTS-1:0]   w_grant_nxt;
    logic [c_idx_w-1:0] r_grant_enc;
    logic [c_idx_w-1:0] w_grant_enc_nxt;
    logic               r_grant_valid;

    logic [PORTS-1:0]   w_last_sh;
    logic [PORTS-1:0]   w_mask;
    logic [PORTS-1:0]   w_req_masked;
    logic [PORTS-1:0]   w_cand;
    logic [PORTS-1:0]   w_sel;
    logic [c_idx_w-1:0] w_sel_idx;
    logic               w_ack_hit;
    logic               w_drop_hit;
    logic               w_release;
    logic               w_arbitrate;

    // One-hot of LAST moved up by one position; bit 0 can never be set, so a
    // LAST of PORTS-1 (or PORTS=1) yields an empty mask.
    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_last_sh
            if (gi == 0) begin : g_bit0
                assign w_last_sh[gi] = 1'b0;
            end else begin : g_bitn
                assign w_last_sh[gi] = (r_last == c_idx_w'(gi - 1));
            end
        end
    endgenerate

    // OR prefix scan: every port strictly above LAST becomes eligible first.
    always_comb begin
        w_mask    = '0;
        w_mask[0] = w_last_sh[0];
        for (int k = 1; k < PORTS; k++) begin
            w_mask[k] = w_mask[k-1] | w_last_sh[k];
        end
    end

    // Prefer requests above LAST; if none, wrap to the full request vector.
    assign w_req_masked = request & w_mask;
    assign w_cand       = (|w_req_masked) ? w_req_masked : request;
    // Isolate the lowest set bit (two's-complement trick).
    assign w_sel        = w_cand & (~w_cand + PORTS'(1));

    always_comb begin
        w_sel_idx = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (w_sel[k]) begin
                w_sel_idx = c_idx_w'(k);
            end
        end
    end

    // Only the granted port's request/acknowledge can release the grant.
    assign w_ack_hit   = |(r_grant & acknowledge);
    assign w_drop_hit  = |(r_grant & ~request);
    assign w_release   = (RELEASE != 0) ? w_ack_hit : w_drop_hit;
    assign w_arbitrate = (r_state == c_st_idle) || w_release;

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_grant_nxt     = r_grant;
        w_grant_enc_nxt = r_grant_enc;
        if (w_arbitrate) begin
            if (|request) begin
                w_state_nxt     = c_st_granted;
                w_grant_nxt     = w_sel;
                w_grant_enc_nxt = w_sel_idx;
                w_last_nxt      = w_sel_idx;
            end else begin
                w_state_nxt     = c_st_idle;
                w_grant_nxt     = '0;
                w_grant_enc_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_last        <= c_last_rst;
            r_grant       <= '0;
            r_grant_enc   <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last        <= w_last_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_enc   <= w_grant_enc_nxt;
            r_grant_valid <= |w_grant_nxt;
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_enc;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter
// Description : Self-checking bench for rr_arbiter. Eight instances cover
//               PORTS in {4,1,3,8} with both release modes. A rotating-search
//               round-robin model predicts every instance each cycle; directed
//               sequences on the two 4-port instances carry literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    localparam int N = 8;

    function automatic int ps(input int k);
        case (k)
            0, 1:    return 4;
            2, 3:    return 1;
            4, 5:    return 3;
            default: return 8;
        endcase
    endfunction

    function automatic int rs(input int k);
        return k % 2;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req [N];
    logic [7:0] ack [N];
    logic [7:0] gnt [N];
    logic [2:0] enc [N];
    logic       val [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < N; k++) begin : g_dut
            localparam int P = ps(k);
            localparam int W = (P > 1) ? $clog2(P) : 1;
            logic [P-1:0] g;
            logic [W-1:0] e;
            logic         v;
            rr_arbiter #(
                .PORTS   (P),
                .RELEASE (rs(k))
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .request       (req[k][P-1:0]),
                .acknowledge   (ack[k][P-1:0]),
                .grant         (g),
                .grant_valid   (v),
                .grant_encoded (e)
            );
            assign gnt[k] = 8'(g);
            assign enc[k] = 3'(e);
            assign val[k] = v;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Model: holder (-1 = none) and last-granted index per instance. On a
    // free cycle it searches ports last+1, last+2, ... cyclically.
    // ------------------------------------------------------------------
    int m_hold [N];
    int m_last [N];
    bit armed = 1'b0;

    always @(posedge clk) begin
        int p, h, idx;
        bit rel;
        for (int k = 0; k < N; k++) begin
            p = ps(k);
            if (rst) begin
                m_hold[k] = -1;
                m_last[k] = p - 1;
            end else begin
                h = m_hold[k];
                if (h < 0)          rel = 1'b1;
                else if (rs(k) == 1) rel = ack[k][h];
                else                rel = !req[k][h];
                if (rel) begin
                    m_hold[k] = -1;
                    for (int j = 1; j <= p; j++) begin
                        idx = (m_last[k] + j) % p;
                        if (m_hold[k] < 0 && req[k][idx]) m_hold[k] = idx;
                    end
                    if (m_hold[k] >= 0) m_last[k] = m_hold[k];
                end
            end
        end
        armed = 1'b1;
    end

    function automatic logic [7:0] model_grant(input int k);
        return (m_hold[k] < 0) ? 8'h00 : 8'(1 << m_hold[k]);
    endfunction

    function automatic logic [2:0] model_enc(input int k);
        return (m_hold[k] < 0) ? 3'd0 : 3'(m_hold[k]);
    endfunction

    task automatic chk_eq(input string nm, input int k,
                          input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0h required=%0h", nm, k, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare, sampled on the falling edge.
    // ------------------------------------------------------------------
    int         waitc   [N][8];
    logic [7:0] prevg   [N];
    logic [7:0] prevreq [N];

    always @(negedge clk) begin
        int  p, mx;
        bit  ev;
        if (armed) begin
            for (int k = 0; k < N; k++) begin
                p = ps(k);
                chk_eq("cyc_grant", k, 32'(gnt[k]), 32'(model_grant(k)));
                chk_eq("cyc_valid", k, 32'(val[k]), 32'(model_grant(k) != 0));
                chk_eq("cyc_enc",   k, 32'(enc[k]), 32'(model_enc(k)));
                checks++;
                if (!$onehot0(gnt[k]) || (val[k] !== (|gnt[k]))) begin
                    errors++;
                    $display("FAIL onehot_valid inst%0d actual grant=%0h valid=%0b required onehot0 and valid=|grant",
                             k, gnt[k], val[k]);
                end
                if (rst) begin
                    for (int b = 0; b < 8; b++) waitc[k][b] = 0;
                end else begin
                    // A new grant observed: count it against every port that
                    // was requesting when the decision was made.
                    ev = (gnt[k] != 8'h00) && (gnt[k] != prevg[k]);
                    mx = 0;
                    for (int b = 0; b < p; b++) begin
                        if (!prevreq[k][b] || gnt[k][b]) waitc[k][b] = 0;
                        else if (ev)                     waitc[k][b]++;
                        if (waitc[k][b] > mx) mx = waitc[k][b];
                    end
                    if (ev) begin
                        checks++;
                        if (mx > p - 1) begin
                            errors++;
                            $display("FAIL starvation inst%0d actual wait=%0d required<=%0d", k, mx, p - 1);
                        end
                    end
                end
                prevg[k]   = gnt[k];
                prevreq[k] = req[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input int k, input logic [7:0] eg, input logic [2:0] ee,
                       input logic ev, input string nm);
        chk_eq({nm, "_grant"}, k, 32'(gnt[k]), 32'(eg));
        chk_eq({nm, "_enc"},   k, 32'(enc[k]), 32'(ee));
        chk_eq({nm, "_valid"}, k, 32'(val[k]), 32'(ev));
        chk_eq({nm, "_model"}, k, 32'(model_grant(k)), 32'(eg));
    endtask

    initial begin
        logic [7:0] msk;
        int p;
        for (int k = 0; k < N; k++) begin
            req[k] = 8'h00;
            ack[k] = 8'h00;
        end
        rst = 1'b1;
        cyc();
        cyc();
        lit(0, 8'h00, 3'd0, 1'b0, "reset_r0");
        lit(1, 8'h00, 3'd0, 1'b0, "reset_r1");
        rst = 1'b0;

        // Single request, held against a higher-priority newcomer.
        req[0] = 8'b0100; cyc(); lit(0, 8'b0100, 3'd2, 1'b1, "single_req");
        req[0] = 8'b0101; cyc(); lit(0, 8'b0100, 3'd2, 1'b1, "hold1");
        cyc();                   lit(0, 8'b0100, 3'd2, 1'b1, "hold2");
        req[0] = 8'b0001; cyc(); lit(0, 8'b0001, 3'd0, 1'b1, "wrap_to_0");
        req[0] = 8'b0000; cyc(); lit(0, 8'h00,   3'd0, 1'b0, "drop_idle");

        // Acknowledge has no effect when RELEASE=0.
        req[0] = 8'b0001; cyc(); lit(0, 8'b0001, 3'd0, 1'b1, "r0_grant");
        ack[0] = 8'b0001; cyc(); lit(0, 8'b0001, 3'd0, 1'b1, "r0_ack_ign");
        ack[0] = 8'h00; req[0] = 8'h00; cyc(); lit(0, 8'h00, 3'd0, 1'b0, "r0_idle");

        // Full rotation with all requests held, no idle cycle between grants.
        rst = 1'b1; cyc(); rst = 1'b0;
        req[0] = 8'b1111; cyc();
        for (int q = 0; q < 4; q++) begin
            lit(0, 8'(1 << q), 3'(q), 1'b1, "rot_first");
            cyc();
            lit(0, 8'(1 << q), 3'(q), 1'b1, "rot_second");
            req[0] = 8'b1111 & ~8'(1 << q);
            cyc();
            req[0] = 8'b1111;
        end
        lit(0, 8'b0001, 3'd0, 1'b1, "rot_wrap");
        req[0] = 8'h00; cyc(); lit(0, 8'h00, 3'd0, 1'b0, "rot_idle");

        // Reset while port 3 holds the grant.
        req[0] = 8'b1000; cyc(); lit(0, 8'b1000, 3'd3, 1'b1, "pre_rst");
        rst = 1'b1; req[0] = 8'b1001; cyc(); lit(0, 8'h00, 3'd0, 1'b0, "rst_drop");
        rst = 1'b0; cyc(); lit(0, 8'b0001, 3'd0, 1'b1, "post_rst");
        req[0] = 8'h00; cyc(); lit(0, 8'h00, 3'd0, 1'b0, "post_idle");

        // RELEASE=1: acknowledge handling.
        req[1] = 8'b0011; cyc(); lit(1, 8'b0001, 3'd0, 1'b1, "r1_grant0");
        ack[1] = 8'b0010; cyc(); lit(1, 8'b0001, 3'd0, 1'b1, "r1_ack_other");
        ack[1] = 8'b0001; cyc(); lit(1, 8'b0010, 3'd1, 1'b1, "r1_next1");
        ack[1] = 8'h00; req[1] = 8'b0010;
        ack[1] = 8'b0010; cyc(); lit(1, 8'b0010, 3'd1, 1'b1, "r1_self_wrap");
        ack[1] = 8'h00; req[1] = 8'h00;
        cyc(); lit(1, 8'b0010, 3'd1, 1'b1, "r1_drop_hold1");
        cyc(); lit(1, 8'b0010, 3'd1, 1'b1, "r1_drop_hold2");
        ack[1] = 8'b0010; cyc(); lit(1, 8'h00, 3'd0, 1'b0, "r1_ack_idle");
        ack[1] = 8'b0001; cyc(); lit(1, 8'h00, 3'd0, 1'b0, "r1_ack_in_idle");
        ack[1] = 8'h00;

        // Random traffic on every instance; the compare process checks it.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                p   = ps(k);
                msk = 8'((1 << p) - 1);
                for (int b = 0; b < p; b++) begin
                    if ($urandom_range(0, 7) == 0) req[k][b] = ~req[k][b];
                end
                req[k] = req[k] & msk;
                ack[k] = 8'($urandom) & 8'($urandom) & msk;
            end
            rst = ((c % 1000) == 500);
            cyc();
        end
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            req[k] = 8'h00;
            ack[k] = 8'h00;
        end
        cyc();
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter PORTS, default 4, number of requesters; legal range 1..64.
REQ-002 Parameter RELEASE, default 0, release mode: 0 = grant released when the granted request drops; 1 = grant released on the acknowledge pulse of the granted port.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port request, input, PORTS, per-port request level.
REQ-006 Port acknowledge, input, PORTS, per-port release pulse; used only when RELEASE=1.
REQ-007 Port grant, output, PORTS, registered one-hot grant.
REQ-008 Port grant_valid, output, 1, registered; high iff grant is non-zero.
REQ-009 Port grant_encoded, output, max(1,$clog2(PORTS)), registered binary index of the granted port; 0 when grant_valid=0.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANTED (one port holds the grant).
REQ-011 The block SHALL keep a last-granted index register LAST; the priority mask SHALL be all ports with index strictly greater than LAST.
REQ-012 The mask SHALL be built with the codebase's OR prefix scan (scan, OP=2) on the one-hot of LAST, shifted up by one.
REQ-013 Selection SHALL be the lowest set bit of (request & mask) if that is non-zero; otherwise the lowest set bit of request.
REQ-014 In IDLE with any request high, the block SHALL move to GRANTED and register grant/grant_encoded/grant_valid on the next edge (latency 1 cycle from request to grant).
REQ-015 In IDLE with request all-zero, outputs SHALL stay zero and LAST SHALL be unchanged.
REQ-016 LAST SHALL update to the selected index on every edge at which a new grant is registered.
REQ-017 In GRANTED, grant SHALL be held constant until the release condition; other requests SHALL NOT change grant.
REQ-018 Release condition: RELEASE=0, request[g]=0 for granted port g; RELEASE=1, acknowledge[g]=1.
REQ-019 On a release cycle the block SHALL arbitrate in the same cycle, using the mask computed from the updated LAST=g, and register the new grant on the next edge (no idle bubble); if no eligible request, go to IDLE with outputs zero.
REQ-020 With RELEASE=1, port g's own request SHALL be eligible on the release cycle and is granted again only if no other port requests (wrap).
REQ-021 Acknowledge on a non-granted port, or in IDLE, SHALL be ignored; acknowledge SHALL be ignored entirely when RELEASE=0.
REQ-022 With RELEASE=1, a dropped request on the granted port without acknowledge SHALL NOT release the grant.
REQ-023 grant SHALL never have more than one bit set; grant_valid SHALL equal |grant at all times.
REQ-024 PORTS=1 SHALL be supported: the mask is always zero, grant follows request per the release rules, and grant_encoded=0.

Reset
REQ-025 With rst high at an edge: grant=0, grant_valid=0, grant_encoded=0, FSM=IDLE, LAST=PORTS-1, so port 0 has highest priority after reset.
REQ-026 Reset SHALL take priority over any simultaneous request, acknowledge or release; reset during GRANTED SHALL drop the grant at that edge.

Verification
REQ-027 PORTS=4, RELEASE=0: request=4'b1111 held, each granted port drops its request for 1 cycle after 2 cycles of grant -> grant order 0,1,2,3,0 with no idle cycle between grants.
REQ-028 PORTS=4, RELEASE=0: request=4'b0100 from reset -> grant=4'b0100, grant_encoded=2 one cycle later; raise request[0] while holding -> grant unchanged.
REQ-029 PORTS=4, RELEASE=1: request=4'b0011, ack port 1 while port 0 is granted -> ignored; ack port 0 -> next grant is port 1; ack port 1 with request=4'b0010 only -> port 1 granted again.
REQ-030 PORTS=4, RELEASE=1: granted port drops its request without acknowledge -> grant held; acknowledge with request=0 -> IDLE and all outputs 0 next cycle.
REQ-031 Reset asserted while port 3 is granted -> all outputs 0 next edge; after rst deasserts with request=4'b1001 -> port 0 granted.
REQ-032 Random request/acknowledge, both RELEASE values, PORTS in {1,3,4,8}, checked every cycle: grant at most one-hot; grant_valid==|grant; grant_encoded matches grant; no starvation (every persistently requesting port is granted within PORTS grants).
